// File: rtl/router_reg_if.sv
// Handshake/data bundle between the router FSM/source side and the router_reg datapath.
interface router_reg_if;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       fifo_full;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       rst_int_reg;
   logic [7:0] dout;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       err;

   modport master (
      output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg,
      input  dout, parity_done, low_pkt_valid, err
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg,
      output dout, parity_done, low_pkt_valid, err
   );
endinterface

// File: rtl/router_reg.sv
// Router datapath register: latches the header, forwards bytes to the FIFO write port,
// parks one byte while the FIFO is full, and checks running XOR parity against the
// received parity byte.
module router_reg (
   input  logic        clock,
   input  logic        resetn,
   router_reg_if.slave bus
);
   logic [7:0] header_reg;
   logic [7:0] full_byte_reg;
   logic [7:0] int_parity;
   logic [7:0] pkt_parity;
   logic [7:0] dout;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       err;

   assign bus.dout          = dout;
   assign bus.parity_done   = parity_done;
   assign bus.low_pkt_valid = low_pkt_valid;
   assign bus.err           = err;

   // Capture the header in DECODE; address 3 is not a real port and is ignored.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         header_reg <= '0;
      end else if (bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11)) begin
         header_reg <= bus.data_in;
      end
   end

   // FIFO write byte; a byte arriving while full is parked and replayed in LOAD_AFTER_FULL.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dout          <= '0;
         full_byte_reg <= '0;
      end else if (bus.lfd_state) begin
         dout <= header_reg;
      end else if (bus.ld_state && !bus.fifo_full) begin
         dout <= bus.data_in;
      end else if (bus.ld_state && bus.fifo_full) begin
         full_byte_reg <= bus.data_in;
      end else if (bus.laf_state) begin
         dout <= full_byte_reg;
      end
   end

   // Running XOR over header and payload; the parity byte itself is never folded in.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         int_parity <= '0;
      end else if (bus.detect_add) begin
         int_parity <= '0;
      end else if (bus.lfd_state) begin
         int_parity <= int_parity ^ header_reg;
      end else if (bus.ld_state && bus.pkt_valid && !bus.full_state) begin
         int_parity <= int_parity ^ bus.data_in;
      end
   end

   // Received parity byte: the LOAD_DATA byte with pkt_valid low.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pkt_parity <= '0;
      end else if (bus.ld_state && !bus.pkt_valid) begin
         pkt_parity <= bus.data_in;
      end
   end

   // End-of-packet seen; held until the FSM reaches the parity check.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         low_pkt_valid <= 1'b0;
      end else if (bus.rst_int_reg) begin
         low_pkt_valid <= 1'b0;
      end else if (bus.ld_state && !bus.pkt_valid) begin
         low_pkt_valid <= 1'b1;
      end
   end

   // Parity byte captured, either directly or after being parked behind a full FIFO.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         parity_done <= 1'b0;
      end else if (bus.detect_add) begin
         parity_done <= 1'b0;
      end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                   (bus.laf_state && low_pkt_valid && !parity_done)) begin
         parity_done <= 1'b1;
      end
   end

   // Parity mismatch flag, evaluated once the parity byte is in.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         err <= 1'b0;
      end else if (bus.detect_add) begin
         err <= 1'b0;
      end else if (parity_done) begin
         err <= (int_parity != pkt_parity);
      end
   end
endmodule

// File: tb/tb_router_reg.sv
// Randomized bench for router_reg: a packet-level generator plays the router FSM and
// predicts every FIFO write, flag and parity verdict from the packet contents.
module tb_router_reg;
   localparam int SIdle = 0, SDa = 1, SLfd = 2, SLd = 3, SLaf = 4, SFull = 5, SChk = 6;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   router_reg_if bus ();

   router_reg dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_dout = '0;
   logic       exp_pd = 1'b0;
   logic       exp_lpv = 1'b0;
   logic       exp_err = 1'b0;
   logic       exp_wr = 1'b0;
   logic       check_en = 1'b0;
   logic [7:0] hdr_m = '0;
   logic [7:0] dout_log[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Per-cycle compare of every output against the packet-level prediction.
   always @(negedge clock) begin
      if (check_en) begin
         chk("dout", bus.dout, exp_dout);
         chk("parity_done", 8'(bus.parity_done), 8'(exp_pd));
         chk("low_pkt_valid", 8'(bus.low_pkt_valid), 8'(exp_lpv));
         chk("err", 8'(bus.err), 8'(exp_err));
         if (exp_wr) dout_log.push_back(bus.dout);
      end
   end

   task automatic set_idle();
      bus.pkt_valid = 1'b0; bus.data_in = '0; bus.fifo_full = 1'b0;
      bus.detect_add = 1'b0; bus.lfd_state = 1'b0; bus.ld_state = 1'b0;
      bus.laf_state = 1'b0; bus.full_state = 1'b0; bus.rst_int_reg = 1'b0;
   endtask

   // One FSM cycle: drive after the falling edge, return just after the rising edge.
   task automatic step(input bit pv, input logic [7:0] din, input bit ff, input int st);
      @(negedge clock);
      bus.pkt_valid   = pv;
      bus.data_in     = din;
      bus.fifo_full   = ff;
      bus.detect_add  = (st == SDa);
      bus.lfd_state   = (st == SLfd);
      bus.ld_state    = (st == SLd);
      bus.laf_state   = (st == SLaf);
      bus.full_state  = (st == SFull);
      bus.rst_int_reg = (st == SChk);
      @(posedge clock);
      exp_wr = 1'b0;
   endtask

   // Full packet: stl[i] < 0 means byte i goes straight in, otherwise it hits a full FIFO
   // and is replayed after stl[i] FIFO_FULL cycles. Index pl.size() is the parity byte.
   task automatic run_packet(input logic [7:0] hdr, input logic [7:0] pl[$],
                             input logic [7:0] par, input int stl[$]);
      logic [7:0] x;
      logic [7:0] b;
      bit         pv;
      step(1'b1, hdr, 1'b0, SDa);
      if (hdr[1:0] != 2'b11) hdr_m = hdr;
      exp_pd = 1'b0; exp_err = 1'b0;
      x = hdr_m;
      foreach (pl[i]) x = x ^ pl[i];
      step(1'b1, (pl.size() > 0) ? pl[0] : par, 1'b0, SLfd);
      exp_dout = hdr_m; exp_wr = 1'b1;
      for (int i = 0; i <= pl.size(); i++) begin
         pv = (i < pl.size());
         b  = pv ? pl[i] : par;
         if (stl[i] < 0) begin
            step(pv, b, 1'b0, SLd);
            exp_dout = b; exp_wr = 1'b1;
            if (!pv) begin exp_pd = 1'b1; exp_lpv = 1'b1; end
         end else begin
            step(pv, b, 1'b1, SLd);
            if (!pv) exp_lpv = 1'b1;
            for (int k = 0; k < stl[i]; k++) step(pv, b, 1'b1, SFull);
            step(pv, b, 1'b0, SLaf);
            exp_dout = b; exp_wr = 1'b1;
            if (!pv) exp_pd = 1'b1;
         end
      end
      step(1'b0, par, 1'b0, SChk);
      exp_lpv = 1'b0;
      exp_err = (x != par);
      step(1'b0, 8'($urandom), 1'b0, SIdle);
   endtask

   task automatic chk_log(input string name, input logic [7:0] want[$]);
      chk({name, "_len"}, 8'(dout_log.size()), 8'(want.size()));
      foreach (want[i]) if (i < dout_log.size()) chk(name, dout_log[i], want[i]);
   endtask

   logic [7:0] pl[$];
   logic [7:0] want[$];
   int         stl[$];

   initial begin
      logic [7:0] hdr, x, par;
      int         len;
      set_idle();
      repeat (3) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      check_en = 1'b1;

      pl = '{8'h11, 8'h22, 8'h33};
      want = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};

      // Good packet
      dout_log.delete();
      stl = '{-1, -1, -1, -1};
      run_packet(8'h0D, pl, 8'h0D, stl);
      chk_log("good_seq", want);
      chk("good_err", 8'(bus.err), 8'h00);
      chk("good_pd", 8'(bus.parity_done), 8'h01);

      // Bad parity
      run_packet(8'h0D, pl, 8'h0C, stl);
      chk("bad_err", 8'(bus.err), 8'h01);

      // FIFO full on 0x22
      dout_log.delete();
      stl = '{-1, 1, -1, -1};
      run_packet(8'h0D, pl, 8'h0D, stl);
      chk_log("full_seq", want);
      chk("full_err", 8'(bus.err), 8'h00);

      // Parity byte parked behind a full FIFO
      dout_log.delete();
      stl = '{-1, -1, -1, 2};
      run_packet(8'h0D, pl, 8'h0D, stl);
      chk_log("lastfull_seq", want);
      chk("lastfull_err", 8'(bus.err), 8'h00);

      // Address 3 header must not replace the stored header
      step(1'b1, 8'h0F, 1'b0, SDa);
      exp_pd = 1'b0; exp_err = 1'b0;
      step(1'b1, 8'h55, 1'b0, SLfd);
      exp_dout = hdr_m;
      step(1'b0, 8'h00, 1'b0, SIdle);
      chk("bad_addr_hdr", bus.dout, 8'h0D);

      // Randomized packets
      for (int n = 0; n < 60; n++) begin
         if (n == 30) begin
            // Reset mid-packet with 0xAB on dout
            step(1'b1, 8'h0D, 1'b0, SDa);
            exp_pd = 1'b0; exp_err = 1'b0; hdr_m = 8'h0D;
            step(1'b1, 8'hAB, 1'b0, SLfd);
            exp_dout = 8'h0D;
            step(1'b1, 8'hAB, 1'b0, SLd);
            exp_dout = 8'hAB;
            @(negedge clock);
            #2;
            chk("pre_reset_dout", bus.dout, 8'hAB);
            check_en = 1'b0;
            set_idle();
            resetn = 1'b0;
            #1;
            chk("rst_dout", bus.dout, 8'h00);
            chk("rst_pd", 8'(bus.parity_done), 8'h00);
            chk("rst_lpv", 8'(bus.low_pkt_valid), 8'h00);
            chk("rst_err", 8'(bus.err), 8'h00);
            @(posedge clock);
            @(negedge clock);
            resetn = 1'b1;
            exp_dout = '0; exp_pd = 1'b0; exp_lpv = 1'b0; exp_err = 1'b0; hdr_m = '0;
            check_en = 1'b1;
         end
         len = $urandom_range(1, 8);
         hdr = {6'(len), 2'($urandom_range(0, 2))};
         pl.delete();
         stl.delete();
         x = hdr;
         for (int i = 0; i < len; i++) begin
            pl.push_back(8'($urandom));
            x = x ^ pl[i];
         end
         for (int i = 0; i <= len; i++)
            stl.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
         par = ($urandom_range(0, 2) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
         run_packet(hdr, pl, par, stl);
         repeat ($urandom_range(0, 2))
            step(1'($urandom), 8'($urandom), 1'($urandom), SIdle);
      end

      @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage directly upstream of `router_fifo` in the 1x3 router. It latches the packet header, forwards header/payload/parity bytes to the FIFO write port on `dout`, and holds one byte aside while the FIFOs are full. It also accumulates a running XOR parity over header and payload and compares it with the received parity byte. Control comes from the router FSM state decodes; status flags go back to that FSM.

## Interface
- No parameters; data width fixed at 8.
- `clock` input 1: single rising-edge clock.
- `resetn` input 1: asynchronous, active-low reset.
- `pkt_valid` input 1: source asserts for header and payload bytes; deasserted on the parity byte.
- `data_in` input 8: source byte; header is `{len[5:0], addr[1:0]}`.
- `fifo_full` input 1: selected FIFO is full.
- `detect_add` input 1: FSM in DECODE_ADDRESS.
- `lfd_state` input 1: FSM in LOAD_FIRST_DATA.
- `ld_state` input 1: FSM in LOAD_DATA.
- `laf_state` input 1: FSM in LOAD_AFTER_FULL.
- `full_state` input 1: FSM in FIFO_FULL_STATE.
- `rst_int_reg` input 1: FSM in CHECK_PARITY_ERROR; clears `low_pkt_valid`.
- `dout` output 8: byte to FIFO `data_in`.
- `parity_done` output 1: parity byte captured.
- `low_pkt_valid` output 1: `pkt_valid` seen low during LOAD_DATA.
- `err` output 1: parity mismatch for current packet.

## Operation
- Internal registers: `header_reg[7:0]`, `full_byte_reg[7:0]`, `int_parity[7:0]`, `pkt_parity[7:0]`. All are cleared by reset.
- Header capture: if `detect_add && pkt_valid && data_in[1:0] != 2'b11`, then `header_reg <= data_in`. Address 3 is never captured.
- `dout` is evaluated in priority order:
  - `lfd_state`: `header_reg`.
  - `ld_state && !fifo_full`: `data_in`.
  - `ld_state && fifo_full`: `full_byte_reg <= data_in`; `dout` holds.
  - `laf_state`: `full_byte_reg`.
  - Otherwise `dout` holds.
- `int_parity` updates:
  - Cleared on `detect_add`.
  - `^= header_reg` on `lfd_state`.
  - `^= data_in` on `ld_state && pkt_valid && !full_state`.
  - Otherwise holds.
  - The parity byte itself is never accumulated.
- `pkt_parity <= data_in` on `ld_state && !pkt_valid`.
- `low_pkt_valid`:
  - Set on `ld_state && !pkt_valid`.
  - Cleared on `rst_int_reg`.
  - Priority: `rst_int_reg` first, then set, then hold.
- `parity_done`:
  - Cleared on `detect_add`.
  - Set on `ld_state && !fifo_full && !pkt_valid`.
  - Also set on `laf_state && low_pkt_valid && !parity_done`.
  - Holds otherwise.
- `err`:
  - Cleared on `detect_add`.
  - When `parity_done == 1`: `err <= (int_parity != pkt_parity)`.
  - Holds otherwise.
- Simultaneous `detect_add` with any load strobe does not occur (FSM states are one-hot). If it does, `detect_add` clear wins.

## Timing
- Reset (async, `resetn = 0`): `dout = 0`, `parity_done = 0`, `low_pkt_valid = 0`, `err = 0`, all internal registers 0. Release is synchronous to the next rising edge.
- Header: captured in the DECODE cycle, driven on `dout` 1 cycle later (edge ending LOAD_FIRST_DATA).
- Payload: 1-cycle latency from `data_in` to `dout`.
- A byte arriving with `fifo_full` high is parked. It appears on `dout` at the edge ending LOAD_AFTER_FULL. No byte is lost or duplicated.
- `parity_done` rises on the edge that samples the parity byte.
- `err` is valid 1 cycle after `parity_done` rises and stays stable until the next `detect_add`.
- Reset mid-packet clears everything. The next packet starts from `detect_add` with `int_parity = 0`.

## Test plan
- Reset: assert `resetn = 0` mid-packet with `dout = 0xAB` -> all outputs read 0 immediately, without waiting for a clock edge.
- Good packet:
  - Stimulus: header 0x0D, payload 0x11, 0x22, 0x33, parity 0x0D, no full.
  - `dout` sequence: 0x0D, 0x11, 0x22, 0x33, 0x0D, each 1 cycle after input.
  - `parity_done = 1` after the parity byte; `err = 0` one cycle later.
- Bad parity: same packet with parity byte 0x0C -> `err = 1` one cycle after `parity_done`. `err` clears on the next `detect_add`.
- FIFO full:
  - Stimulus: raise `fifo_full` while byte 0x22 is on `data_in` in `ld_state`.
  - `dout` holds 0x11.
  - In `laf_state`, `dout = 0x22`.
  - Final `int_parity` still equals 0x0D, so `err = 0`.
- Parity on last-after-full: `pkt_valid` low (parity 0x0D) while `fifo_full` high -> `low_pkt_valid = 1`, `parity_done` stays 0. `parity_done` sets in `laf_state`; `rst_int_reg` then clears `low_pkt_valid`.
- Invalid address: header 0x0F (addr 3) during `detect_add` -> `header_reg` keeps its previous value.
